// File: rtl/window_sum.sv
// window_sum: running sum and average over the last DEPTH accepted samples
module window_sum #(
   parameter int W     = 32,
   parameter int DEPTH = 8,
   localparam int L    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           clr,
   input  logic [W-1:0]   x,
   output logic [W+L-1:0] y,
   output logic [W-1:0]   avg,
   output logic [L:0]     cnt,
   output logic           full
);
   logic [W-1:0] mem [DEPTH];
   logic [L-1:0] wp;
   logic [W-1:0] old;
   assign old = full ? mem[wp] : '0;
   assign avg = y[W+L-1:L];
   // sample buffer: write the accepted sample over the oldest slot, no reset needed
   always_ff @(posedge clk)
      if (en && !clr) mem[wp] <= x;
   // window bookkeeping: running sum, pointer, saturating count and full flag
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         y    <= '0;
         cnt  <= '0;
         wp   <= '0;
         full <= 1'b0;
      end else if (clr) begin
         y    <= '0;
         cnt  <= '0;
         wp   <= '0;
         full <= 1'b0;
      end else if (en) begin
         y    <= (W+L)'({1'b0, y} + (W+L+1)'(x) - (W+L+1)'(old));
         wp   <= wp + L'(1);
         cnt  <= full ? cnt : cnt + (L+1)'(1);
         full <= full | (cnt == (L+1)'(DEPTH-1));
      end
endmodule
